match_ctrl: RTL

MATCH_CTRL -- requirements
Module: match_ctrl

---
 rtl/match_ctrl_pkg.sv | 30 +++
 rtl/match_ctrl_player_select.sv | 60 ++++++
 rtl/match_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/match_ctrl_pkg.sv
// match_pkg: FSM state encodings, default parameter values and skill codes
// shared by match_ctrl and player_select.
package match_pkg;

    typedef enum logic [2:0] {
        ST_SELECT      = 3'd0,
        ST_PLAYING     = 3'd1,
        ST_ROUND_END   = 3'd2,
        ST_RESET_PULSE = 3'd3,
        ST_MATCH_END   = 3'd4
    } state_t;

    localparam int unsigned DEF_WIN_ROUNDS = 2;
    localparam int unsigned DEF_END_DELAY  = 200000000;
    localparam int unsigned DEF_RESET_HOLD = 4;

    localparam logic [1:0] SKILL_0 = 2'd0;
    localparam logic [1:0] SKILL_1 = 2'd1;
    localparam logic [1:0] SKILL_2 = 2'd2;
    localparam logic [1:0] SKILL_3 = 2'd3;

    // Step the skill selection one position with wrap-around in both directions.
    function automatic logic [1:0] skill_step(input logic [1:0] sel, input logic up);
        if (up)
            return (sel == SKILL_3) ? SKILL_0 : sel + 2'd1;
        else
            return (sel == SKILL_0) ? SKILL_3 : sel - 2'd1;
    endfunction

endpackage

// File: rtl/match_ctrl_player_select.sv
// player_select: per-player button edge detection, skill selection with wrap,
// and the ready latch. Instantiated once per player by match_ctrl.
module player_select
    import match_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_confirm,
    input  logic       i_sel_en,
    input  logic       i_lock,
    input  logic       i_clr_ready,
    output logic [1:0] o_sel,
    output logic       o_ready,
    output logic       o_confirm_edge
);

    logic       r_left_q;
    logic       r_right_q;
    logic       r_confirm_q;
    logic [1:0] r_sel;
    logic       r_ready;
    logic       w_left_edge;
    logic       w_right_edge;

    assign w_left_edge    = i_left    & ~r_left_q;
    assign w_right_edge   = i_right   & ~r_right_q;
    assign o_confirm_edge = i_confirm & ~r_confirm_q;
    assign o_sel          = r_sel;
    assign o_ready        = r_ready;

    // Edge registers come out of reset high so a button held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_left_q    <= 1'b1;
            r_right_q   <= 1'b1;
            r_confirm_q <= 1'b1;
        end else begin
            r_left_q    <= i_left;
            r_right_q   <= i_right;
            r_confirm_q <= i_confirm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sel   <= SKILL_0;
            r_ready <= 1'b0;
        end else if (i_clr_ready) begin
            r_ready <= 1'b0;
        end else if (i_sel_en && !r_ready) begin
            if (o_confirm_edge)
                r_ready <= 1'b1;
            else if (!i_lock && (w_left_edge ^ w_right_edge))
                r_sel <= skill_step(r_sel, w_right_edge);
        end
    end

endmodule

// File: rtl/match_ctrl.sv
// match_ctrl: best-of match sequencer around the game controller.
// Optional MATCH_SKILL_LOCK_EN freezes skill selection after the first round of a match.
module match_ctrl
    import match_pkg::*;
#(
    parameter int unsigned WIN_ROUNDS = DEF_WIN_ROUNDS,
    parameter int unsigned END_DELAY  = DEF_END_DELAY,
    parameter int unsigned RESET_HOLD = DEF_RESET_HOLD
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       p1_left,
    input  logic       p1_right,
    input  logic       p1_confirm,
    input  logic       p2_left,
    input  logic       p2_right,
    input  logic       p2_confirm,
    input  logic       game_start,
    input  logic       game_over,
    input  logic       p1_win,
    output logic [1:0] p1_skill_sel,
    output logic [1:0] p2_skill_sel,
    output logic       p1_ready,
    output logic       p2_ready,
    output logic       game_reset,
    output logic [2:0] p1_score,
    output logic [2:0] p2_score,
    output logic       match_over,
    output logic       match_p1_win,
    output logic [2:0] state
);

    localparam int unsigned DW  = (END_DELAY  > 1) ? $clog2(END_DELAY)  : 1;
    localparam int unsigned HW  = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [2:0]  WIN = 3'(WIN_ROUNDS);

    state_t        r_state;
    logic [DW-1:0] r_delay;
    logic [HW-1:0] r_hold;
    logic [2:0]    r_p1_score;
    logic [2:0]    r_p2_score;
    logic          r_match_over;
    logic          r_match_p1_win;
    logic          r_game_reset;
    logic          w_sel_en;
    logic          w_lock;
    logic          w_p1_conf;
    logic          w_p2_conf;
    logic          w_match_won;
    logic          w_to_pulse;

    assign w_sel_en    = (r_state == ST_SELECT);
    assign w_match_won = (r_p1_score == WIN) || (r_p2_score == WIN);
    // Ready flags drop on the same edge that enters RESET_PULSE.
    assign w_to_pulse  = ((r_state == ST_ROUND_END) && (r_delay == '0) && !w_match_won)
                      || ((r_state == ST_MATCH_END) && (w_p1_conf || w_p2_conf));

`ifdef MATCH_SKILL_LOCK_EN
    logic r_locked;
    always_ff @(posedge clk) begin
        if (!rstn)
            r_locked <= 1'b0;
        else if ((r_state == ST_PLAYING) && game_over)
            r_locked <= 1'b1;
        else if ((r_state == ST_MATCH_END) && (w_p1_conf || w_p2_conf))
            r_locked <= 1'b0;
    end
    assign w_lock = r_locked;
`else
    assign w_lock = 1'b0;
`endif

    player_select u_p1 (
        .clk(clk), .rstn(rstn),
        .i_left(p1_left), .i_right(p1_right), .i_confirm(p1_confirm),
        .i_sel_en(w_sel_en), .i_lock(w_lock), .i_clr_ready(w_to_pulse),
        .o_sel(p1_skill_sel), .o_ready(p1_ready), .o_confirm_edge(w_p1_conf)
    );

    player_select u_p2 (
        .clk(clk), .rstn(rstn),
        .i_left(p2_left), .i_right(p2_right), .i_confirm(p2_confirm),
        .i_sel_en(w_sel_en), .i_lock(w_lock), .i_clr_ready(w_to_pulse),
        .o_sel(p2_skill_sel), .o_ready(p2_ready), .o_confirm_edge(w_p2_conf)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state        <= ST_SELECT;
            r_delay        <= '0;
            r_hold         <= '0;
            r_p1_score     <= '0;
            r_p2_score     <= '0;
            r_match_over   <= 1'b0;
            r_match_p1_win <= 1'b0;
            r_game_reset   <= 1'b0;
        end else begin
            case (r_state)
                ST_SELECT: begin
                    if (game_start)
                        r_state <= ST_PLAYING;
                end
                ST_PLAYING: begin
                    if (game_over) begin
                        if (p1_win) begin
                            if (r_p1_score < WIN) r_p1_score <= r_p1_score + 3'd1;
                        end else begin
                            if (r_p2_score < WIN) r_p2_score <= r_p2_score + 3'd1;
                        end
                        r_delay <= DW'(END_DELAY - 1);
                        r_state <= ST_ROUND_END;
                    end
                end
                ST_ROUND_END: begin
                    if (r_delay != '0) begin
                        r_delay <= r_delay - 1'b1;
                    end else if (w_match_won) begin
                        r_state        <= ST_MATCH_END;
                        r_match_over   <= 1'b1;
                        r_match_p1_win <= (r_p1_score == WIN);
                    end else begin
                        r_state      <= ST_RESET_PULSE;
                        r_hold       <= HW'(RESET_HOLD - 1);
                        r_game_reset <= 1'b1;
                    end
                end
                ST_RESET_PULSE: begin
                    if (r_hold != '0) begin
                        r_hold <= r_hold - 1'b1;
                    end else begin
                        r_state      <= ST_SELECT;
                        r_game_reset <= 1'b0;
                    end
                end
                ST_MATCH_END: begin
                    if (w_p1_conf || w_p2_conf) begin
                        r_p1_score     <= '0;
                        r_p2_score     <= '0;
                        r_match_over   <= 1'b0;
                        r_match_p1_win <= 1'b0;
                        r_hold         <= HW'(RESET_HOLD - 1);
                        r_game_reset   <= 1'b1;
                        r_state        <= ST_RESET_PULSE;
                    end
                end
                default: r_state <= ST_SELECT;
            endcase
        end
    end

    assign p1_score     = r_p1_score;
    assign p2_score     = r_p2_score;
    assign match_over   = r_match_over;
    assign match_p1_win = r_match_p1_win;
    assign game_reset   = r_game_reset;
    assign state        = r_state;

endmodule
